// File: rtl/contatore_mod.sv
// contatore_mod: parametrised modulo-N up/down counter with synchronous load,
// count enable, combinational terminal-count flag and registered wrap pulse.
// Optional feature macro: CONTATORE_SATURATE_EN -- when defined the counter
// holds at its boundary instead of wrapping, and the wrap pulse never fires.
module contatore_mod #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic [WIDTH-1:0] o_out,
  output logic             o_tc,
  output logic             o_wrap
);

  // Reject out-of-range configurations at elaboration time.
  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("contatore_mod: WIDTH must be in 1..16");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("contatore_mod: MODULUS must be in 2..2**WIDTH");
  end

  // One extra bit of headroom so the clamp compare and +/-1 never alias.
  localparam logic [WIDTH:0] C_MAX = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] C_ONE = (WIDTH+1)'(1);

  logic [WIDTH-1:0] r_out;
  logic             r_wrap;

  logic [WIDTH:0]   w_cur;
  logic [WIDTH:0]   w_lv;
  logic [WIDTH:0]   w_next;
  logic             w_wrap_next;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_unused_msb;

  assign w_cur     = {1'b0, r_out};
  assign w_lv      = {1'b0, i_load_value};
  assign w_at_max  = (w_cur == C_MAX);
  assign w_at_zero = (w_cur == '0);

  // Terminal count doubles as the carry-enable for a cascaded stage.
  assign o_tc   = i_en & (i_up ? w_at_max : w_at_zero);
  assign o_out  = r_out;
  assign o_wrap = r_wrap;

  // The next value never exceeds MODULUS-1, so the headroom bit is always 0.
  assign w_unused_msb = w_next[WIDTH];

  // Next-state: load beats count, count beats hold; wrap only on a boundary step.
  always_comb begin
    w_next      = w_cur;
    w_wrap_next = 1'b0;
    if (i_load) begin
      w_next = (w_lv > C_MAX) ? C_MAX : w_lv;
    end else if (i_en) begin
      if (i_up) begin
        if (w_at_max) begin
`ifdef CONTATORE_SATURATE_EN
          w_next = w_cur;
`else
          w_next      = '0;
          w_wrap_next = 1'b1;
`endif
        end else begin
          w_next = w_cur + C_ONE;
        end
      end else begin
        if (w_at_zero) begin
`ifdef CONTATORE_SATURATE_EN
          w_next = w_cur;
`else
          w_next      = C_MAX;
          w_wrap_next = 1'b1;
`endif
        end else begin
          w_next = w_cur - C_ONE;
        end
      end
    end
  end

  // Count and wrap registers, cleared immediately by reset.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_out  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_out  <= w_next[WIDTH-1:0];
      r_wrap <= w_wrap_next;
    end
  end

endmodule

// File: tb/tb_contatore_mod.sv
// tb_contatore_mod: directed self-checking bench for contatore_mod.
// Main instance WIDTH=3/MODULUS=6; a WIDTH=4/MODULUS=16 pair is cascaded via tc.
module tb_contatore_mod;

  typedef struct {
    logic [2:0] out;
    logic       wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       up  = 1'b1;
  logic       load = 1'b0;
  logic [2:0] lv  = 3'd0;
  logic [2:0] out;
  logic       tc, wrap;

  logic       cen = 1'b0;
  logic [3:0] lo_out, hi_out;
  logic       lo_tc, hi_tc, lo_wrap, hi_wrap;

  int   vectors = 0;
  int   errs    = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  contatore_mod #(.WIDTH(3), .MODULUS(6)) dut (
    .i_clock(clk), .i_reset(rst), .i_en(en), .i_up(up), .i_load(load),
    .i_load_value(lv), .o_out(out), .o_tc(tc), .o_wrap(wrap)
  );

  contatore_mod #(.WIDTH(4), .MODULUS(16)) u_lo (
    .i_clock(clk), .i_reset(rst), .i_en(cen), .i_up(1'b1), .i_load(1'b0),
    .i_load_value(4'd0), .o_out(lo_out), .o_tc(lo_tc), .o_wrap(lo_wrap)
  );

  contatore_mod #(.WIDTH(4), .MODULUS(16)) u_hi (
    .i_clock(clk), .i_reset(rst), .i_en(lo_tc), .i_up(1'b1), .i_load(1'b0),
    .i_load_value(4'd0), .o_out(hi_out), .o_tc(hi_tc), .o_wrap(hi_wrap)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] expv);
    vectors++;
    assert (got === expv) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // Drive one set of inputs, check tc before the edge, queue the post-edge result.
  task automatic step(input string tag, input logic e, input logic u, input logic l,
                      input logic [2:0] v, input logic etc,
                      input logic [2:0] eo, input logic ew);
    exp_t x;
    @(negedge clk);
    en = e; up = u; load = l; lv = v;
    sb.push_back('{out: eo, wrap: ew});
    #1 chk({tag, "_tc"}, 16'(tc), 16'(etc));
    @(posedge clk); #1;
    x = sb.pop_front();
    chk({tag, "_out"},  16'(out),  16'(x.out));
    chk({tag, "_wrap"}, 16'(wrap), 16'(x.wrap));
  endtask

  initial begin
    int hi_wraps;
    int lo_wraps;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1 chk("rst_out", 16'(out), 16'd0);
    chk("rst_wrap", 16'(wrap), 16'd0);
    chk("rst_tc_idle", 16'(tc), 16'd0);
    en = 1'b1; up = 1'b0;
    #1 chk("rst_tc_down", 16'(tc), 16'd1);
    en = 1'b0; up = 1'b1;
    @(negedge clk); rst = 1'b0;

`ifndef CONTATORE_SATURATE_EN
    // Up count through the wrap.
    step("up1", 1, 1, 0, 0, 0, 3'd1, 0);
    step("up2", 1, 1, 0, 0, 0, 3'd2, 0);
    step("up3", 1, 1, 0, 0, 0, 3'd3, 0);
    step("up4", 1, 1, 0, 0, 0, 3'd4, 0);
    step("up5", 1, 1, 0, 0, 0, 3'd5, 0);
    step("up6", 1, 1, 0, 0, 1, 3'd0, 1);
    step("up7", 1, 1, 0, 0, 0, 3'd1, 0);
    // Down count through the underflow.
    step("dn1", 1, 0, 0, 0, 0, 3'd0, 0);
    step("dn2", 1, 0, 0, 0, 1, 3'd5, 1);
    step("dn3", 1, 0, 0, 0, 0, 3'd4, 0);
`else
    // Saturation at both ends.
    step("sld4", 0, 1, 1, 3'd4, 0, 3'd4, 0);
    step("sup1", 1, 1, 0, 0, 0, 3'd5, 0);
    step("sup2", 1, 1, 0, 0, 1, 3'd5, 0);
    step("sup3", 1, 1, 0, 0, 1, 3'd5, 0);
    step("sld1", 0, 1, 1, 3'd1, 0, 3'd1, 0);
    step("sdn1", 1, 0, 0, 0, 0, 3'd0, 0);
    step("sdn2", 1, 0, 0, 0, 1, 3'd0, 0);
    step("sld4b", 0, 1, 1, 3'd4, 0, 3'd4, 0);
`endif
    // Hold, then loads with clamping and load-over-count priority.
    step("hold",  0, 1, 0, 0,    0, 3'd4, 0);
    step("ld7",   1, 1, 1, 3'd7, 0, 3'd5, 0);
    step("ld3",   0, 1, 1, 3'd3, 0, 3'd3, 0);
    step("ld6",   0, 1, 1, 3'd6, 0, 3'd5, 0);
    step("ldpri", 1, 1, 1, 3'd2, 1, 3'd2, 0);
    step("ld3b",  0, 1, 1, 3'd3, 0, 3'd3, 0);
    step("upto4", 1, 1, 0, 0,    0, 3'd4, 0);

    // Reset mid-count, held across an edge, released just after an edge.
    @(negedge clk); #2 rst = 1'b1;
    #1 chk("amid_out", 16'(out), 16'd0);
    chk("amid_wrap", 16'(wrap), 16'd0);
    @(posedge clk); #1 chk("rhold_out", 16'(out), 16'd0);
    @(posedge clk); #1 rst = 1'b0;
    chk("rrel_out", 16'(out), 16'd0);
    @(posedge clk); #1 chk("rfirst_out", 16'(out), 16'd1);
    chk("rfirst_wrap", 16'(wrap), 16'd0);
    @(negedge clk); en = 1'b0;

`ifndef CONTATORE_SATURATE_EN
    // Cascade: 256 edges cover the full 8-bit range exactly once.
    hi_wraps = 0;
    lo_wraps = 0;
    @(negedge clk); cen = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      @(posedge clk); #1;
      chk("casc_val", {8'd0, hi_out, lo_out}, 16'(k % 256));
      if (hi_wrap) hi_wraps++;
      if (lo_wrap) lo_wraps++;
    end
    chk("casc_hi_wraps", 16'(hi_wraps), 16'd1);
    chk("casc_lo_wraps", 16'(lo_wraps), 16'd16);
    chk("casc_hi_tc", 16'(hi_tc), 16'd0);
    @(negedge clk); cen = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  // Hard bound so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
